magazine_ctrl: RTL and testbench

- Holds the shotgun magazine for one round. It sits directly downstream of the bullet/item generator.
- Latches the generated bullet bitmap and bullet count on a load pulse, then serves fire, eject, invert and peek requests from the game FSM one bullet at a time.
- Publishes remaining, live and blank counts for the display and AI logic.
- Raises a reload request when the magazine runs empty so the top level regenerates and reloads.

---
 rtl/magazine_ctrl_pkg.sv | 6 +
 rtl/magazine_ctrl_if.sv | 36 +++
 rtl/magazine_ctrl_popcount8.sv | 14 +
 rtl/magazine_ctrl.sv | 109 ++++++++++
 tb/tb_magazine_ctrl.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/magazine_ctrl_pkg.sv
// magazine_ctrl_pkg: shared state, depth and command encodings for the magazine
package magazine_ctrl_pkg;
  localparam int MAX_BULLETS = 8;
  typedef enum logic {S_EMPTY, S_READY} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_LOAD, CMD_SHOOT, CMD_EJECT, CMD_INVERT, CMD_PEEK} cmd_t;
endpackage

// File: rtl/magazine_ctrl_if.sv
// magazine_ctrl_if: command and result bundle between the game FSM and the magazine
interface magazine_ctrl_if import magazine_ctrl_pkg::*; #(
  parameter int MAX_BULLETS = magazine_ctrl_pkg::MAX_BULLETS,
  parameter int CNT_W = 4
);
  logic i_load;
  logic [MAX_BULLETS-1:0] i_bullet_bitmap;
  logic [CNT_W-1:0] i_bullet_num;
  logic i_shoot;
  logic i_eject;
  logic i_invert;
  logic i_peek;
  logic o_fire_valid;
  logic o_fire_live;
  logic o_eject_valid;
  logic o_eject_live;
  logic o_peek_valid;
  logic o_peek_live;
  logic [CNT_W-1:0] o_remaining;
  logic [CNT_W-1:0] o_live_cnt;
  logic [CNT_W-1:0] o_blank_cnt;
  logic o_empty;
  logic o_reload_req;
  logic o_cmd_drop;
  logic o_load_err;
  modport master (
    output i_load, i_bullet_bitmap, i_bullet_num, i_shoot, i_eject, i_invert, i_peek,
    input o_fire_valid, o_fire_live, o_eject_valid, o_eject_live, o_peek_valid, o_peek_live,
    input o_remaining, o_live_cnt, o_blank_cnt, o_empty, o_reload_req, o_cmd_drop, o_load_err
  );
  modport slave (
    input i_load, i_bullet_bitmap, i_bullet_num, i_shoot, i_eject, i_invert, i_peek,
    output o_fire_valid, o_fire_live, o_eject_valid, o_eject_live, o_peek_valid, o_peek_live,
    output o_remaining, o_live_cnt, o_blank_cnt, o_empty, o_reload_req, o_cmd_drop, o_load_err
  );
endinterface

// File: rtl/magazine_ctrl_popcount8.sv
// popcount8: combinational count of live bits in a bullet bitmap
module popcount8 #(
  parameter int W = 8,
  parameter int CW = 4
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_cnt
);
  // ripple sum of set bits
  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < W; k++) o_cnt = o_cnt + CW'(i_bits[k]);
  end
endmodule

// File: rtl/magazine_ctrl.sv
// magazine_ctrl: holds one round's magazine and serves fire/eject/invert/peek one bullet at a time
module magazine_ctrl import magazine_ctrl_pkg::*; #(
  parameter int MAX_BULLETS = magazine_ctrl_pkg::MAX_BULLETS,
  parameter int CNT_W = 4
) (
  input logic i_clk,
  input logic i_rst_n,
  magazine_ctrl_if.slave bus
);
  state_t r_state, w_state_n;
  cmd_t w_cmd;
  logic [MAX_BULLETS-1:0] r_mag, w_mag_n, w_masked;
  logic [CNT_W-1:0] r_rem, r_live, r_blank, w_rem_n, w_live_n, w_blank_n, w_pop;
  logic r_fire_v, r_fire_l, r_eject_v, r_eject_l, r_peek_v, r_peek_l, r_reload, r_drop, r_load_err;
  logic w_fire_v_n, w_fire_l_n, w_eject_v_n, w_eject_l_n, w_peek_v_n, w_peek_l_n;
  logic w_reload_n, w_drop_n, w_load_err_n, w_num_ok;
  assign w_num_ok = bus.i_bullet_num != '0 && bus.i_bullet_num <= CNT_W'(MAX_BULLETS);
  assign w_cmd = bus.i_load ? CMD_LOAD : bus.i_shoot ? CMD_SHOOT : bus.i_eject ? CMD_EJECT :
                 bus.i_invert ? CMD_INVERT : bus.i_peek ? CMD_PEEK : CMD_NONE;
  // clear bitmap bits beyond the loaded bullet count
  always_comb begin
    w_masked = '0;
    for (int k = 0; k < MAX_BULLETS; k++) w_masked[k] = bus.i_bullet_bitmap[k] & (CNT_W'(k) < bus.i_bullet_num);
  end
  popcount8 #(.W(MAX_BULLETS), .CW(CNT_W)) u_pop (.i_bits(w_masked), .o_cnt(w_pop));
  // next-state, magazine/count update and result pulses for the winning command
  always_comb begin
    w_state_n = r_state;
    w_mag_n = r_mag;
    w_rem_n = r_rem;
    w_live_n = r_live;
    w_blank_n = r_blank;
    w_fire_v_n = 1'b0;
    w_fire_l_n = r_fire_l;
    w_eject_v_n = 1'b0;
    w_eject_l_n = r_eject_l;
    w_peek_v_n = 1'b0;
    w_peek_l_n = r_peek_l;
    w_reload_n = 1'b0;
    w_load_err_n = 1'b0;
    w_drop_n = $countones({bus.i_load, bus.i_shoot, bus.i_eject, bus.i_invert, bus.i_peek}) > 1 ||
               (r_state == S_EMPTY && w_cmd != CMD_NONE && w_cmd != CMD_LOAD);
    case (w_cmd)
      CMD_LOAD: if (w_num_ok) begin
        w_mag_n = w_masked;
        w_rem_n = bus.i_bullet_num;
        w_live_n = w_pop;
        w_blank_n = bus.i_bullet_num - w_pop;
        w_state_n = S_READY;
      end else w_load_err_n = 1'b1;
      CMD_SHOOT, CMD_EJECT: if (r_state == S_READY) begin
        w_mag_n = r_mag >> 1;
        w_rem_n = r_rem - CNT_W'(1);
        w_live_n = r_live - CNT_W'(r_mag[0]);
        w_blank_n = r_blank - CNT_W'(!r_mag[0]);
        w_fire_v_n = w_cmd == CMD_SHOOT;
        w_fire_l_n = w_cmd == CMD_SHOOT ? r_mag[0] : r_fire_l;
        w_eject_v_n = w_cmd == CMD_EJECT;
        w_eject_l_n = w_cmd == CMD_EJECT ? r_mag[0] : r_eject_l;
        w_reload_n = r_rem == CNT_W'(1);
        w_state_n = r_rem == CNT_W'(1) ? S_EMPTY : S_READY;
      end
      CMD_INVERT: if (r_state == S_READY) begin
        w_mag_n[0] = ~r_mag[0];
        w_live_n = r_mag[0] ? r_live - CNT_W'(1) : r_live + CNT_W'(1);
        w_blank_n = r_mag[0] ? r_blank + CNT_W'(1) : r_blank - CNT_W'(1);
      end
      CMD_PEEK: if (r_state == S_READY) begin
        w_peek_v_n = 1'b1;
        w_peek_l_n = r_mag[0];
      end
      default: ;
    endcase
  end
  // state, magazine, counts and registered results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
      r_mag <= '0;
      r_rem <= '0;
      r_live <= '0;
      r_blank <= '0;
      {r_fire_v, r_fire_l, r_eject_v, r_eject_l, r_peek_v, r_peek_l} <= '0;
      {r_reload, r_drop, r_load_err} <= '0;
    end else begin
      r_state <= w_state_n;
      r_mag <= w_mag_n;
      r_rem <= w_rem_n;
      r_live <= w_live_n;
      r_blank <= w_blank_n;
      {r_fire_v, r_fire_l, r_eject_v, r_eject_l, r_peek_v, r_peek_l} <=
        {w_fire_v_n, w_fire_l_n, w_eject_v_n, w_eject_l_n, w_peek_v_n, w_peek_l_n};
      {r_reload, r_drop, r_load_err} <= {w_reload_n, w_drop_n, w_load_err_n};
    end
  end
  assign bus.o_fire_valid = r_fire_v;
  assign bus.o_fire_live = r_fire_l;
  assign bus.o_eject_valid = r_eject_v;
  assign bus.o_eject_live = r_eject_l;
  assign bus.o_peek_valid = r_peek_v;
  assign bus.o_peek_live = r_peek_l;
  assign bus.o_remaining = r_rem;
  assign bus.o_live_cnt = r_live;
  assign bus.o_blank_cnt = r_blank;
  assign bus.o_empty = r_state == S_EMPTY;
  assign bus.o_reload_req = r_reload;
  assign bus.o_cmd_drop = r_drop;
  assign bus.o_load_err = r_load_err;
endmodule

// File: tb/tb_magazine_ctrl.sv
// tb_magazine_ctrl: directed self-checking bench for the magazine controller
module tb_magazine_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_asrt = 0;
  int n_fail = 0;
  int reloads;
  logic [3:0] exp_fire;
  magazine_ctrl_if #(.MAX_BULLETS(8), .CNT_W(4)) bus ();
  magazine_ctrl #(.MAX_BULLETS(8), .CNT_W(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic counts(input string tag, input int rem, input int live, input int blank);
    chk({tag, "_rem"}, 32'(bus.o_remaining), rem);
    chk({tag, "_live"}, 32'(bus.o_live_cnt), live);
    chk({tag, "_blank"}, 32'(bus.o_blank_cnt), blank);
  endtask
  task automatic cmd(input logic ld, input logic [7:0] bm, input logic [3:0] num,
                     input logic sh, input logic ej, input logic inv, input logic pk);
    @(negedge clk);
    bus.i_load = ld;
    bus.i_bullet_bitmap = bm;
    bus.i_bullet_num = num;
    bus.i_shoot = sh;
    bus.i_eject = ej;
    bus.i_invert = inv;
    bus.i_peek = pk;
    @(posedge clk);
    #1;
    {bus.i_load, bus.i_shoot, bus.i_eject, bus.i_invert, bus.i_peek} = '0;
  endtask
  initial begin
    {bus.i_load, bus.i_shoot, bus.i_eject, bus.i_invert, bus.i_peek} = '0;
    bus.i_bullet_bitmap = '0;
    bus.i_bullet_num = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    counts("reset", 0, 0, 0);
    chk("reset_empty", 32'(bus.o_empty), 1);
    chk("reset_fire_valid", 32'(bus.o_fire_valid), 0);
    chk("reset_reload", 32'(bus.o_reload_req), 0);
    chk("reset_drop", 32'(bus.o_cmd_drop), 0);
    chk("reset_load_err", 32'(bus.o_load_err), 0);
    @(negedge clk) rst_n = 1'b1;
    cmd(1, 8'b00000110, 4, 0, 0, 0, 0);
    counts("load1", 4, 2, 2);
    chk("load1_empty", 32'(bus.o_empty), 0);
    chk("load1_err", 32'(bus.o_load_err), 0);
    exp_fire = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 0, 1, 0, 0, 0);
      chk($sformatf("shoot%0d_valid", i), 32'(bus.o_fire_valid), 1);
      chk($sformatf("shoot%0d_live", i), 32'(bus.o_fire_live), 32'(exp_fire[i]));
      chk($sformatf("shoot%0d_reload", i), 32'(bus.o_reload_req), i == 3);
      chk($sformatf("shoot%0d_drop", i), 32'(bus.o_cmd_drop), 0);
      chk($sformatf("shoot%0d_rem", i), 32'(bus.o_remaining), 3 - i);
    end
    chk("shoot_empty", 32'(bus.o_empty), 1);
    counts("shoot_end", 0, 0, 0);
    cmd(0, 0, 0, 0, 0, 0, 0);
    chk("idle_fire_valid", 32'(bus.o_fire_valid), 0);
    chk("idle_reload", 32'(bus.o_reload_req), 0);
    cmd(1, 8'b11111111, 6, 0, 0, 0, 0);
    counts("load2", 6, 6, 0);
    reloads = 0;
    for (int i = 0; i < 6; i++) begin
      cmd(0, 0, 0, 0, 1, 0, 0);
      chk($sformatf("eject%0d_valid", i), 32'(bus.o_eject_valid), 1);
      chk($sformatf("eject%0d_live", i), 32'(bus.o_eject_live), 1);
      chk($sformatf("eject%0d_fire_valid", i), 32'(bus.o_fire_valid), 0);
      reloads += int'(bus.o_reload_req);
    end
    counts("eject_end", 0, 0, 0);
    chk("eject_reloads", reloads, 1);
    chk("eject_empty", 32'(bus.o_empty), 1);
    cmd(1, 8'b00000001, 2, 0, 0, 0, 0);
    counts("load3", 2, 1, 1);
    cmd(0, 0, 0, 0, 0, 0, 1);
    chk("peek1_valid", 32'(bus.o_peek_valid), 1);
    chk("peek1_live", 32'(bus.o_peek_live), 1);
    cmd(0, 0, 0, 0, 0, 1, 0);
    chk("invert_peek_valid", 32'(bus.o_peek_valid), 0);
    counts("invert", 2, 0, 2);
    cmd(0, 0, 0, 0, 0, 0, 1);
    chk("peek2_valid", 32'(bus.o_peek_valid), 1);
    chk("peek2_live", 32'(bus.o_peek_live), 0);
    cmd(0, 0, 0, 1, 0, 0, 0);
    chk("inv_shoot_live", 32'(bus.o_fire_live), 0);
    counts("inv_shoot", 1, 0, 1);
    cmd(0, 0, 0, 1, 0, 0, 1);
    chk("prio_fire_valid", 32'(bus.o_fire_valid), 1);
    chk("prio_peek_valid", 32'(bus.o_peek_valid), 0);
    chk("prio_drop", 32'(bus.o_cmd_drop), 1);
    chk("prio_rem", 32'(bus.o_remaining), 0);
    chk("prio_reload", 32'(bus.o_reload_req), 1);
    cmd(0, 0, 0, 1, 0, 0, 0);
    chk("empty_shoot_drop", 32'(bus.o_cmd_drop), 1);
    chk("empty_shoot_valid", 32'(bus.o_fire_valid), 0);
    chk("empty_shoot_reload", 32'(bus.o_reload_req), 0);
    cmd(1, 8'b00000011, 0, 0, 0, 0, 0);
    chk("num0_err", 32'(bus.o_load_err), 1);
    chk("num0_empty", 32'(bus.o_empty), 1);
    cmd(1, 8'b00000011, 9, 0, 0, 0, 0);
    chk("num9_err", 32'(bus.o_load_err), 1);
    chk("num9_empty", 32'(bus.o_empty), 1);
    chk("num9_rem", 32'(bus.o_remaining), 0);
    cmd(1, 8'b00000111, 5, 0, 0, 0, 0);
    chk("load4_err", 32'(bus.o_load_err), 0);
    counts("load4", 5, 3, 2);
    cmd(0, 0, 0, 1, 0, 0, 0);
    cmd(0, 0, 0, 1, 0, 0, 0);
    chk("load4_shoot_live", 32'(bus.o_fire_live), 1);
    counts("load4_shot", 3, 1, 2);
    cmd(1, 8'b10101010, 8, 0, 0, 0, 0);
    counts("reload8", 8, 4, 4);
    chk("reload8_empty", 32'(bus.o_empty), 0);
    cmd(1, 8'b11111111, 0, 0, 0, 0, 0);
    chk("ready_bad_err", 32'(bus.o_load_err), 1);
    chk("ready_bad_empty", 32'(bus.o_empty), 0);
    counts("ready_bad", 8, 4, 4);
    cmd(0, 0, 0, 1, 0, 0, 0);
    chk("last_shoot_valid", 32'(bus.o_fire_valid), 1);
    chk("last_shoot_live", 32'(bus.o_fire_live), 0);
    counts("last_shoot", 7, 4, 3);
    #2 rst_n = 1'b0;
    #1;
    counts("async_rst", 0, 0, 0);
    chk("async_rst_empty", 32'(bus.o_empty), 1);
    chk("async_rst_fire_valid", 32'(bus.o_fire_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    cmd(0, 0, 0, 1, 0, 0, 0);
    chk("post_rst_drop", 32'(bus.o_cmd_drop), 1);
    chk("post_rst_fire_valid", 32'(bus.o_fire_valid), 0);
    chk("post_rst_rem", 32'(bus.o_remaining), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
